c_inst_sequencer: RTL
=====================

// Module: c_inst_sequencer
// PURPOSE
//  Parametrised compressed-instruction sequencer: holds a loadable program of 16-bit RVC
//  words and issues them to the decode/execute datapath over a valid/ready handshake.
//  Supports multi-pass looping, halts on c.ebreak and counts retired instructions.
//  Replaces hard-coded cycle-indexed stimulus in front of decoder/regfile/int/shift units.
// PARAMETERS
//  DEPTH   32  program buffer entries (power of 2, >=2); AW = $clog2(DEPTH)
//  ILEN    16  instruction word width
//  CNT_W   16  loop_count width
// PORTS
//  clk         in   1        clock, all state updates on posedge
//  rst         in   1        synchronous, active-high reset
//  ld_valid    in   1        program write strobe
//  ld_addr     in   AW       program write index
//  ld_data     in   ILEN     program write data
//  start       in   1        begin run (accepted in IDLE or HALT)
//  prog_len    in   AW+1     instructions per pass, sampled on start (>DEPTH clamps to DEPTH)
//  loop_count  in   CNT_W    passes, sampled on start; 0 treated as 1
//  inst_valid  out  1        instruction offered
//  inst_data   out  ILEN     instruction word = mem[idx]
//  inst_pc     out  32       byte address = idx*2
//  inst_ready  in   1        datapath accepts; handshake = inst_valid & inst_ready
//  wb_valid    in   1        datapath register writeback strobe
//  wb_rd       in   5        writeback register index
//  wb_data     in   32       writeback value
//  busy        out  1        state == RUN
//  done        out  1        one-cycle pulse: run completed normally
//  halted      out  1        level: stopped on c.ebreak
//  retired     out  32       handshakes since last start, wraps at 2^32
//  signature   out  32       writeback signature (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; inst_valid, busy, done, halted = 0; retired, idx, pass, signature = 0;
//    all mem entries = 16'h0001 (c.nop). inst_data/inst_pc = 0 while !inst_valid.
//  - States IDLE, RUN, HALT. inst_valid = (state == RUN), no extra latency.
//  - ld_valid: written at the edge only in IDLE or HALT; ignored in RUN. Write and start in
//    the same cycle: write commits, first issue sees new contents.
//  - IDLE/HALT + start: prog_len==0 -> done pulse next cycle, state IDLE, no issue.
//    Otherwise -> RUN, idx=0, pass=0, retired=0, halted=0, signature=0. start in RUN ignored.
//  - RUN, no handshake: idx, inst_data, inst_pc held stable.
//  - RUN, handshake: retired+1. If inst_data == 16'h9002 (c.ebreak) -> HALT, halted=1.
//    Else if idx == len-1: pass == loops-1 -> IDLE, done=1 next cycle;
//    else idx=0, pass+1. Else idx+1.
//  - ebreak on the last instruction of the last pass: HALT wins, no done.
//  - idx never exceeds len-1; no wrap past DEPTH-1.
//  - rst mid-RUN: returns to reset state next cycle and drops the in-flight offer.
//  - wb_* ignored unless CONFIGURATION macro defined.
// CONFIGURATION
//  SEQ_SIGNATURE_EN defined: on wb_valid & wb_rd != 0 in any state,
//    signature <= {signature[30:0], signature[31]} ^ wb_data ^ {27'b0, wb_rd}.
//    Cleared on reset and on accepted start.
//  Not defined: signature tied to 32'h0, no signature flops.
// TESTING
//  1. Load 4705,4781,97BA,0705 @0..3; len=4, loops=1, ready=1 -> 4 beats, pc 0,2,4,6; done
//     1 cycle after 4th beat; retired=4.
//  2. As 1, inst_ready=0 for 3 cycles at beat 2 -> inst_data=4781, pc=2 held; retired=4 at end.
//  3. len=2, loops=3 -> 6 beats, pc 0,2,0,2,0,2; single done; retired=6.
//  4. mem[1]=9002, len=4 -> 2 beats, halted=1, inst_valid=0, no done; start -> halted=0, pc=0.
//  5. rst during RUN after 2 beats -> next cycle inst_valid=0, busy=0, retired=0, mem[0]=0001.
//  6. SEQ_SIGNATURE_EN: wb (rd=15,data=3) from sig=0 -> sig=0000000C; rd=0 -> unchanged.

Source files
------------

// File: rtl/c_inst_sequencer.sv
// RVC program sequencer: issues buffered 16-bit words over valid/ready, loops, halts on c.ebreak.
// Zero-latency offer from state; inst_ready low holds idx/data/pc. SEQ_SIGNATURE_EN adds the writeback signature.
`timescale 1ns/1ps
module c_inst_sequencer #(
    parameter int DEPTH = 32,
    parameter int ILEN  = 16,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    input  logic [ILEN-1:0]  ld_data,
    input  logic             start,
    input  logic [AW:0]      prog_len,
    input  logic [CNT_W-1:0] loop_count,
    output logic             inst_valid,
    output logic [ILEN-1:0]  inst_data,
    output logic [31:0]      inst_pc,
    input  logic             inst_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic [31:0]      retired,
    output logic [31:0]      signature
);

    localparam logic [ILEN-1:0] C_NOP    = ILEN'(16'h0001);
    localparam logic [ILEN-1:0] C_EBREAK = ILEN'(16'h9002);
    localparam logic [AW:0]     MAX_LEN  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t            state;
    logic [ILEN-1:0]   mem [DEPTH];
    logic [AW-1:0]     idx;
    logic [AW:0]       len;
    logic [CNT_W-1:0]  pass;
    logic [CNT_W-1:0]  loops;
    logic [ILEN-1:0]   cur_inst;
    logic              fire;
    logic              last_idx;
    logic              last_pass;
    logic              can_start;

    assign cur_inst   = mem[idx];
    assign inst_valid = (state == S_RUN);
    assign busy       = (state == S_RUN);
    assign fire       = inst_valid & inst_ready;
    assign last_idx   = ({1'b0, idx} == (len - (AW+1)'(1)));
    assign last_pass  = (pass == (loops - CNT_W'(1)));
    assign can_start  = start & (state != S_RUN);

    // Outputs read as zero whenever nothing is offered.
    assign inst_data = inst_valid ? cur_inst : '0;
    assign inst_pc   = inst_valid ? {{(31-AW){1'b0}}, idx, 1'b0} : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            len     <= '0;
            pass    <= '0;
            loops   <= '0;
            done    <= 1'b0;
            halted  <= 1'b0;
            retired <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= C_NOP;
            end
        end else begin
            done <= 1'b0;
            // The program is frozen while it is being issued.
            if (ld_valid && state != S_RUN) begin
                mem[ld_addr] <= ld_data;
            end
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        halted <= 1'b0;
                        if (prog_len == '0) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_RUN;
                            idx     <= '0;
                            pass    <= '0;
                            retired <= 32'h0;
                            len     <= (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
                            loops   <= (loop_count == '0) ? CNT_W'(1) : loop_count;
                        end
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        retired <= retired + 32'd1;
                        if (cur_inst == C_EBREAK) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else if (last_idx) begin
                            if (last_pass) begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end else begin
                                idx  <= '0;
                                pass <= pass + CNT_W'(1);
                            end
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_SIGNATURE_EN
    logic [31:0] sig;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= 32'h0;
        end else if (can_start) begin
            sig <= 32'h0;
        end else if (wb_valid && wb_rd != 5'd0) begin
            sig <= {sig[30:0], sig[31]} ^ wb_data ^ {27'b0, wb_rd};
        end
    end

    assign signature = sig;
`else
    logic unused_wb;

    assign unused_wb = ^{wb_valid, wb_rd, wb_data, can_start};
    assign signature = 32'h0;
`endif

endmodule
